// File: rtl/sar_bs_ctrl.sv
// Binary-search SAR controller for a 4-bit ADC with a unary (thermometer) DAC.
// Walks the trial code MSB-first and publishes both binary and thermometer results.
module sar_bs_ctrl #(
  parameter int N_BITS        = 4,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_comp_in,
  output logic                   o_sample_en,
  output logic                   o_busy,
  output logic [2**N_BITS-1:0]   o_dac_therm,
  output logic                   o_done,
  output logic [N_BITS-1:0]      o_result_bin,
  output logic [2**N_BITS-1:0]   o_result_therm
);

  localparam int THERM_W = 2**N_BITS;
  localparam int IDX_W   = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SAMPLE  = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]         r_state;
  logic               r_start;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [N_BITS-1:0]  r_trial;
  logic [THERM_W-1:0] r_dacTherm;
  logic [N_BITS-1:0]  r_resultBin;
  logic [THERM_W-1:0] r_resultTherm;

  logic [1:0]         w_stateNext;
  logic [CNT_W-1:0]   w_cntNext;
  logic [IDX_W-1:0]   w_idxNext;
  logic [IDX_W-1:0]   w_idxDec;
  logic [N_BITS-1:0]  w_trialNext;
  logic               w_loadResult;

  // Bit j is set iff j < v; the top bit can never be reached by a 0..THERM_W-1 code.
  function automatic logic [THERM_W-1:0] therm(input logic [N_BITS-1:0] v);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int j = 0; j < THERM_W - 1; j++) begin
      t[j] = (j < int'(v));
    end
    return t;
  endfunction

  assign w_idxDec = r_idx - 1'b1;

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_idxNext    = r_idx;
    w_trialNext  = r_trial;
    w_loadResult = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_stateNext = S_SAMPLE;
          w_cntNext   = '0;
          w_trialNext = '0;
        end
      end
      S_SAMPLE: begin
        if (i_abort) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
          w_trialNext = '0;
        end else if (r_cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
          w_stateNext              = S_CONVERT;
          w_cntNext                = '0;
          w_idxNext                = IDX_W'(N_BITS - 1);
          w_trialNext              = '0;
          w_trialNext[N_BITS-1]    = 1'b1;
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_CONVERT: begin
        // Abort outranks the bit decision that would otherwise land on this edge.
        if (i_abort) begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
          w_trialNext = '0;
        end else if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_cntNext            = '0;
          w_trialNext[r_idx]   = i_comp_in;
          if (r_idx == '0) begin
            w_stateNext  = S_DONE;
            w_loadResult = 1'b1;
          end else begin
            w_idxNext              = w_idxDec;
            w_trialNext[w_idxDec]  = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
        w_trialNext = '0;
      end
      default: begin
        w_stateNext = S_IDLE;
        w_trialNext = '0;
      end
    endcase
  end

  // Start is captured one edge before it launches the sample phase, and only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_start       <= 1'b0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_trial       <= '0;
      r_dacTherm    <= '0;
      r_resultBin   <= '0;
      r_resultTherm <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_start    <= i_start && (r_state == S_IDLE) && !r_start;
      r_cnt      <= w_cntNext;
      r_idx      <= w_idxNext;
      r_trial    <= w_trialNext;
      r_dacTherm <= therm(w_trialNext);
      if (w_loadResult) begin
        r_resultBin   <= w_trialNext;
        r_resultTherm <= therm(w_trialNext);
      end
    end
  end

  assign o_sample_en    = (r_state == S_SAMPLE);
  assign o_busy         = (r_state == S_SAMPLE) || (r_state == S_CONVERT);
  assign o_done         = (r_state == S_DONE);
  assign o_dac_therm    = r_dacTherm;
  assign o_result_bin   = r_resultBin;
  assign o_result_therm = r_resultTherm;

endmodule

// File: tb/tb_sar_bs_ctrl.sv
// Directed bench for sar_bs_ctrl: a default instance and a SAMPLE=1/SETTLE=3 instance
// share start/abort/reset, each driven by an ideal comparator against the same vin.
module tb_sar_bs_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  vinReg = 4'd0;

  logic        comp1, se1, busy1, done1;
  logic [15:0] dac1, rt1;
  logic [3:0]  rb1;
  logic        comp2, se2, busy2, done2;
  logic [15:0] dac2, rt2;
  logic [3:0]  rb2;

  int checks = 0;
  int failures = 0;

  int doneK1, doneK2, doneCnt1, doneCnt2, busyCnt1, busyCnt2, seCnt1, seCnt2, badTherm;
  int busyAfter1, busyAfter2, seAfter1;
  logic [15:0] dacAfter1, dacAfter2;
  int popAt [0:22];

  always #5 clk = ~clk;

  assign comp1 = int'(vinReg) >= $countones(dac1);
  assign comp2 = int'(vinReg) >= $countones(dac2);

  sar_bs_ctrl dut1 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_comp_in(comp1),
    .o_sample_en(se1), .o_busy(busy1), .o_dac_therm(dac1), .o_done(done1),
    .o_result_bin(rb1), .o_result_therm(rt1)
  );

  sar_bs_ctrl #(.N_BITS(4), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort), .i_comp_in(comp2),
    .o_sample_en(se2), .o_busy(busy2), .o_dac_therm(dac2), .o_done(done2),
    .o_result_bin(rb2), .o_result_therm(rt2)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] thermOf(input int v);
    logic [31:0] t;
    t = (32'd1 << v) - 32'd1;
    return t[15:0];
  endfunction

  function automatic bit validTherm(input logic [15:0] d);
    return (d == thermOf($countones(d))) && !d[15];
  endfunction

  // Start sampled at edge E; k counts edges after E. Strobe/abort indices of -1 mean unused.
  task automatic applyStimulus(input logic [3:0] vin, input int sA, input int sB, input int abortK);
    vinReg = vin;
    doneK1 = 0; doneK2 = 0; doneCnt1 = 0; doneCnt2 = 0;
    busyCnt1 = 0; busyCnt2 = 0; seCnt1 = 0; seCnt2 = 0; badTherm = 0;
    busyAfter1 = -1; busyAfter2 = -1; seAfter1 = -1; dacAfter1 = 16'hDEAD; dacAfter2 = 16'hDEAD;
    for (int i = 0; i <= 22; i++) popAt[i] = -1;
    start = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 22; k++) begin
      start = (sA >= 0 && k - 1 == sA) || (sB >= 0 && k - 1 == sB);
      abort = (abortK >= 0 && k - 1 == abortK);
      @(posedge clk); #1;
      popAt[k] = $countones(dac1);
      if (done1) begin doneCnt1++; if (doneK1 == 0) doneK1 = k; end
      if (done2) begin doneCnt2++; if (doneK2 == 0) doneK2 = k; end
      if (busy1) busyCnt1++;
      if (busy2) busyCnt2++;
      if (se1) seCnt1++;
      if (se2) seCnt2++;
      if (!validTherm(dac1) || !validTherm(dac2) || rt1[15] || rt2[15]) badTherm++;
      if (abortK >= 0 && k == abortK + 1) begin
        busyAfter1 = int'(busy1); busyAfter2 = int'(busy2); seAfter1 = int'(se1);
        dacAfter1 = dac1; dacAfter2 = dac2;
      end
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic checkRun(input string nm, input int exp1, input int exp2, input bit aborted);
    if (!aborted) begin
      checkOutput({nm, "_lat1"}, doneK1, 11);
      checkOutput({nm, "_lat2"}, doneK2, 14);
      checkOutput({nm, "_busy1"}, busyCnt1, 10);
      checkOutput({nm, "_busy2"}, busyCnt2, 13);
      checkOutput({nm, "_se1"}, seCnt1, 2);
      checkOutput({nm, "_se2"}, seCnt2, 1);
      checkOutput({nm, "_ndone1"}, doneCnt1, 1);
      checkOutput({nm, "_ndone2"}, doneCnt2, 1);
    end else begin
      checkOutput({nm, "_ndone1"}, doneCnt1, 0);
      checkOutput({nm, "_ndone2"}, doneCnt2, 0);
      checkOutput({nm, "_busyAfter1"}, busyAfter1, 0);
      checkOutput({nm, "_busyAfter2"}, busyAfter2, 0);
      checkOutput({nm, "_seAfter1"}, seAfter1, 0);
      checkOutput({nm, "_dacAfter1"}, dacAfter1, 16'h0000);
      checkOutput({nm, "_dacAfter2"}, dacAfter2, 16'h0000);
    end
    checkOutput({nm, "_rb1"}, rb1, exp1);
    checkOutput({nm, "_rt1"}, rt1, thermOf(exp1));
    checkOutput({nm, "_rb2"}, rb2, exp2);
    checkOutput({nm, "_rt2"}, rt2, thermOf(exp2));
    checkOutput({nm, "_badTherm"}, badTherm, 0);
    checkOutput({nm, "_dacIdle1"}, dac1, 16'h0000);
  endtask

  initial begin
    #12;
    checkOutput("rst_ctl1", {se1, busy1, done1}, 3'b000);
    checkOutput("rst_dat1", {dac1, rt1, rb1}, 36'h0);
    checkOutput("rst_ctl2", {se2, busy2, done2}, 3'b000);
    checkOutput("rst_dat2", {dac2, rt2, rb2}, 36'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    applyStimulus(4'd10, -1, -1, -1);
    checkRun("vin10", 10, 10, 0);
    checkOutput("vin10_trial8", popAt[3], 8);
    checkOutput("vin10_trial12", popAt[5], 12);
    checkOutput("vin10_trial10", popAt[7], 10);
    checkOutput("vin10_trial11", popAt[9], 11);
    checkOutput("vin10_rbConst", rb1, 4'hA);
    checkOutput("vin10_rtConst", rt1, 16'h03FF);
    checkOutput("vin10_sampleDac", popAt[1], 0);

    applyStimulus(4'd0, -1, -1, -1);
    checkRun("vin0", 0, 0, 0);
    checkOutput("vin0_rtConst", rt1, 16'h0000);

    applyStimulus(4'd15, -1, -1, -1);
    checkRun("vin15", 15, 15, 0);
    checkOutput("vin15_rbConst", rb1, 4'hF);
    checkOutput("vin15_rtConst", rt1, 16'h7FFF);
    checkOutput("vin15_rt2Const", rt2, 16'h7FFF);

    for (int v = 0; v < 16; v++) begin
      applyStimulus(4'(v), -1, -1, -1);
      checkRun($sformatf("sweep%0d", v), v, v, 0);
    end

    applyStimulus(4'd5, 4, 11, -1);
    checkRun("ignStart", 5, 5, 0);

    // Abort sampled on the dut1 bit-1 cycle, which is also dut2's bit-2 decision edge.
    applyStimulus(4'd9, -1, -1, 7);
    checkRun("abort", 5, 5, 1);
    applyStimulus(4'd9, -1, -1, -1);
    checkRun("postAbort", 9, 9, 0);

    vinReg = 4'd12;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("preRst_busy1", busy1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst_ctl1", {se1, busy1, done1}, 3'b000);
    checkOutput("midRst_dat1", {dac1, rt1, rb1}, 36'h0);
    checkOutput("midRst_ctl2", {se2, busy2, done2}, 3'b000);
    checkOutput("midRst_dat2", {dac2, rt2, rb2}, 36'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'd6, -1, -1, -1);
    checkRun("afterRst", 6, 6, 0);

    applyStimulus(4'd5, -1, -1, -1);
    checkRun("vin5", 5, 5, 0);
    checkOutput("vin5_rb2Const", rb2, 4'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sar_bs_ctrl.md
Name: sar_bs_ctrl

Overview:
Successive-approximation binary-search controller for a 4-bit SAR ADC with a unary (thermometer) DAC. It runs the sample phase, walks the trial code MSB-first using the clocked comparator decision, and drives the DAC with the thermometer form of the current trial code. Its result_therm output feeds the downstream thermometer-to-binary encoder. It also provides the binary result directly for cross-checking.

Parameters:
N_BITS, 4, resolution; thermometer width THERM_W = 2**N_BITS (localparam, 16).
SAMPLE_CYCLES, 2, cycles sample_en is held high (>=1).
SETTLE_CYCLES, 2, cycles per bit trial before the comparator is sampled (>=1).

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  conversion request; honoured only in IDLE.
abort  in  1  cancel the conversion in progress.
comp_in  in  1  comparator decision, synchronous to clk; 1 = input >= DAC level.
sample_en  out  1  track/hold switch control.
busy  out  1  high in SAMPLE and CONVERT.
dac_therm  out  THERM_W  thermometer code of the current trial value.
done  out  1  one-cycle pulse when the result updates.
result_bin  out  N_BITS  last completed binary result.
result_therm  out  THERM_W  last completed result in thermometer form; goes to the encoder.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs are 0, including trial, counters, result_bin and result_therm.
- Thermometer rule for trial value v (0..15): bit j = 1 iff j < v, for j = 0..14. Bit 15 is always 0.
  - Example: v=10 gives 16'h03FF.
  - dac_therm = therm(trial); result_therm = therm(result_bin). Both are registered.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: when start=1, go to SAMPLE on the next edge and clear trial to 0. Otherwise hold.
- SAMPLE: sample_en=1 and busy=1 for exactly SAMPLE_CYCLES cycles, with dac_therm=0.
  - On the last cycle's edge, go to CONVERT with bit index i=N_BITS-1 and trial[i] set.
- CONVERT: each bit lasts exactly SETTLE_CYCLES cycles. On the edge ending the last cycle:
  - trial[i] stays set if comp_in=1, otherwise it is cleared.
  - If i>0: decrement i and set the new trial[i] on the same edge.
  - If i=0: go to DONE. result_bin is loaded with the final trial and result_therm is updated on that same edge.
- DONE: one cycle. done=1, busy=0, then IDLE. start is ignored in DONE.
- Latency: with start sampled at edge E, done is high in the cycle after edge E+1+SAMPLE_CYCLES+N_BITS*SETTLE_CYCLES. With defaults this is E+11.
- The edge that ends DONE also clears trial to 0, so dac_therm returns to 0 in IDLE.
- start while busy is ignored; no queuing.
- abort=1 in SAMPLE or CONVERT:
  - next state IDLE, trial cleared, sample_en=0, no done pulse.
  - result_bin and result_therm keep their previous values.
- abort has priority over a simultaneous bit decision or DONE transition. abort in IDLE or DONE has no effect.
- result_bin and result_therm change only on the edge entering DONE, and are stable otherwise.
- Asynchronous reset mid-conversion returns to IDLE with all outputs 0 immediately.

Test Plan:
- Reset during CONVERT -> all outputs 0 asynchronously; start after release -> normal conversion.
- Comparator model comp_in=(vin>=trial_value), vin=10 -> trials 8,12,10,11 with keep/clear/keep/clear. Expected result:
  - result_bin=4'hA, result_therm=16'h03FF.
  - done exactly at E+11, busy high for 10 cycles, sample_en high 2 cycles.
- vin=0 -> result_bin=0, result_therm=16'h0000. vin=15 -> result_bin=4'hF, result_therm=16'h7FFF, with bit 15 never set.
- Sweep vin 0..15 -> result_bin=vin. Each dac_therm value observed during the sweep is a valid thermometer code with popcount equal to the trial value.
- start pulsed during CONVERT and in DONE -> ignored, single done pulse. abort at bit 1 -> IDLE next cycle, no done, previous result retained.
- SAMPLE_CYCLES=1, SETTLE_CYCLES=3 -> done at E+1+1+12, vin=5 gives result_bin=5.
